dmem_lsu: RTL
=============

Name: dmem_lsu

Overview:
Byte-addressed, little-endian data memory with a RISC-V load/store front end, the parametrised successor of the fixed 1 KiB word RAM.
- Supports byte, half and word accesses, with sign or zero extension on loads.
- Flags misaligned accesses and suppresses them.
- Inserts a configurable number of wait states.
- Clears the array with a multi-cycle sweep after reset.
- Sits between the core's MEM stage and the data array, using a valid/ready request and a one-cycle response pulse.

Parameters:
ADDR_W, 10, byte-address width; array holds 2**ADDR_W bytes, organised as 2**(ADDR_W-2) words of 4 byte lanes.
WAIT_CYCLES, 0, extra wait states between request accept and response (0..15).
INIT_CLEAR, 1, 1 = zero the whole array after reset; 0 = skip the sweep (contents undefined).

Ports:
clk  in  1  clock; all logic updates on the rising edge.
rst  in  1  synchronous, active-high reset.
req_valid  in  1  request present.
req_ready  out  1  block can accept a request this cycle.
req_we  in  1  1 = store, 0 = load.
req_addr  in  ADDR_W  byte address.
req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
req_unsigned  in  1  loads only: 1 = zero-extend (lbu/lhu), 0 = sign-extend.
req_wdata  in  32  store data, LSB-justified.
rsp_valid  out  1  one-cycle response pulse; no backpressure.
rsp_rdata  out  32  extended load data; 0 for stores and errors.
rsp_err  out  1  misaligned or illegal-size access; valid with rsp_valid.
init_busy  out  1  clear sweep in progress.

Behaviour:
- Reset: at a clock edge with rst=1, outputs take these values:
  - req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - init_busy=INIT_CLEAR; clear counter=0.
  - State goes to CLEAR if INIT_CLEAR=1, otherwise IDLE.
- rst mid-operation aborts any pending access with no write and no response. A mid-sweep rst restarts the sweep at word 0.
- States:
  - CLEAR: writes 0 to word[cnt] each cycle; cnt increments. After word 2**(ADDR_W-2)-1, go to IDLE with init_busy=0. Sweep takes exactly 2**(ADDR_W-2) cycles.
  - IDLE: req_ready=1. On req_valid&&req_ready, latch the request. Go to WAIT with wait counter=WAIT_CYCLES-1, or directly to RESP if WAIT_CYCLES=0.
  - WAIT: req_ready=0; counter decrements; go to RESP on the edge where the counter is 0.
  - RESP: rsp_valid=1 for this cycle only. req_ready=1, so a new request can be accepted here (same transitions as IDLE); otherwise go to IDLE.
- Latency is WAIT_CYCLES+1 cycles from the accept edge to rsp_valid. Peak throughput is one access per WAIT_CYCLES+1 cycles.
- Commit point: the store write and the load array sample both occur at the edge entering RESP.
  - A load accepted in the RESP cycle of a store to the same address returns the new data.
- Alignment: an access is misaligned if it is a half with addr[0]=1, a word with addr[1:0]!=0, or req_size=11. For any of these:
  - rsp_err=1 and rsp_rdata=0.
  - No array write.
- Store lanes:
  - Byte: wdata[7:0] goes to lane addr[1:0].
  - Half: wdata[15:0] goes to lanes {addr[1],0} and {addr[1],1}.
  - Word: all four lanes.
  - Unselected lanes are unchanged.
- Load extraction: the same lane selection applies; bit 7 (byte) or bit 15 (half) is replicated into the upper bits unless req_unsigned=1. For words, req_unsigned is ignored.
- Stores respond with rsp_valid=1, rsp_rdata=0 and rsp_err per the alignment check.
- rsp_rdata and rsp_err hold their values until the next response; they are only meaningful while rsp_valid=1.
- req_valid during CLEAR or WAIT is not accepted. The requester holds the request until ready.
- The address range is always in bounds; there is no wrap logic.

Test Plan:
1. Reset, default params → init_busy=1 for exactly 256 cycles, then req_ready=1. Loads of words 0x000 and 0x3FC return 0x00000000.
2. With WAIT_CYCLES=0:
   - Store word 0x80F0A0B0 @0x010, then back-to-back lb @0x013 → 0xFFFFFF80.
   - lbu @0x013 → 0x00000080.
   - lh @0x010 → 0xFFFFA0B0.
   - lhu @0x012 → 0x000080F0.
   - Each response arrives 1 cycle after its accept, with no idle cycles between accepts.
3. Sub-word store: sb 0x55 @0x011, then lw @0x010 → 0x80F055B0; the other lanes are unchanged.
4. Misalignment: sh @0x021 and lw @0x022 → rsp_err=1, rsp_rdata=0. A following lw @0x020 returns the prior contents, proving no write occurred. req_size=11 also gives rsp_err=1.
5. With WAIT_CYCLES=3:
   - rsp_valid rises exactly 4 cycles after accept.
   - req_ready=0 during the 3 wait cycles; a req_valid held there is accepted in the RESP cycle.
6. Assert rst in the WAIT state of a store to 0x040 → no rsp_valid and no write. The sweep restarts at word 0 (init_busy=1 for 256 cycles), after which lw @0x040 returns 0.

Source files
------------

// File: rtl/dmem_lsu_if.sv
// Load/store request and response bundle between the MEM stage
// and the byte-addressed data memory.
interface dmem_lsu_if #(
  parameter int ADDR_W = 10
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              init_busy;

  modport master (
    output req_valid, req_we, req_addr,
    output req_size, req_unsigned, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata,
    input  rsp_err, init_busy
  );

  modport slave (
    input  req_valid, req_we, req_addr,
    input  req_size, req_unsigned, req_wdata,
    output req_ready, rsp_valid, rsp_rdata,
    output rsp_err, init_busy
  );
endinterface

// File: rtl/dmem_lsu.sv
// Little-endian byte/half/word data memory with RISC-V load/store
// front end, wait-state insertion and post-reset clear sweep.
module dmem_lsu #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 0,
  parameter bit INIT_CLEAR  = 1'b1
) (
  input logic       clk,
  input logic       rst,
  dmem_lsu_if.slave bus
);

  localparam int WI    = ADDR_W - 2;
  localparam int WORDS = 2 ** WI;
  localparam logic [3:0] WLOAD =
    (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_CLEAR,
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        size;
    logic              uns;
    logic [31:0]       wdata;
  } req_t;

  state_e          state_q, state_d;
  logic [WI-1:0]   cnt_q, cnt_d;
  logic [3:0]      wcnt_q, wcnt_d;
  req_t            req_q, req_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;

  logic [31:0]     mem_q [WORDS];

  req_t            in_req, cur;
  logic            rdy, accept, commit, mis;
  logic            is_b, is_h, is_w;
  logic [WI-1:0]   widx;
  logic [31:0]     word, sh, ext, wlane;
  logic [3:0]      be;

  assign in_req = {bus.req_we, bus.req_addr, bus.req_size,
                   bus.req_unsigned, bus.req_wdata};
  assign accept = bus.req_valid && rdy;

  // Array commit happens on the edge that enters RESP.
  assign commit = (accept && (WAIT_CYCLES == 0)) ||
                  (state_q == S_WAIT && wcnt_q == 4'd0);
  assign cur    = (state_q == S_WAIT) ? req_q : in_req;

  assign is_b = (cur.size == 2'b00);
  assign is_h = (cur.size == 2'b01);
  assign is_w = (cur.size == 2'b10);
  assign mis  = (cur.size == 2'b11) ||
                (is_h && cur.addr[0]) ||
                (is_w && (cur.addr[1:0] != 2'b00));

  assign widx = cur.addr[ADDR_W-1:2];
  assign word = mem_q[widx];
  assign sh   = word >> {cur.addr[1:0], 3'b000};

  always_comb begin
    be    = 4'b0000;
    wlane = cur.wdata;
    ext   = word;
    unique case (1'b1)
      is_b: begin
        be    = 4'b0001 << cur.addr[1:0];
        wlane = {4{cur.wdata[7:0]}};
        ext   = {{24{sh[7] & ~cur.uns}}, sh[7:0]};
      end
      is_h: begin
        be    = cur.addr[1] ? 4'b1100 : 4'b0011;
        wlane = {2{cur.wdata[15:0]}};
        ext   = {{16{sh[15] & ~cur.uns}}, sh[15:0]};
      end
      is_w: begin
        be    = 4'b1111;
        ext   = word;
      end
      default: begin
        be    = 4'b0000;
        ext   = 32'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT_CLEAR ? S_CLEAR : S_IDLE;
      cnt_q   <= '0;
      wcnt_q  <= '0;
      req_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wcnt_q  <= wcnt_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wcnt_d  = wcnt_q;
    req_d   = req_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      S_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (&cnt_q) state_d = S_IDLE;
      end
      S_IDLE, S_RESP: begin
        state_d = S_IDLE;
        if (accept) begin
          req_d = in_req;
          if (WAIT_CYCLES == 0) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            wcnt_d  = WLOAD;
          end
        end
      end
      S_WAIT: begin
        wcnt_d = wcnt_q - 4'd1;
        if (wcnt_q == 4'd0) state_d = S_RESP;
      end
      default: state_d = S_IDLE;
    endcase
    if (commit) begin
      rdata_d = (cur.we || mis) ? 32'd0 : ext;
      err_d   = mis;
    end
  end

  always_comb begin
    rdy           = !rst &&
                    (state_q == S_IDLE || state_q == S_RESP);
    bus.req_ready = rdy;
    bus.rsp_valid = (state_q == S_RESP);
    bus.init_busy = (state_q == S_CLEAR);
    bus.rsp_rdata = rdata_q;
    bus.rsp_err   = err_q;
  end

  // The array has no reset; an aborted access never reaches it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == S_CLEAR) begin
        mem_q[cnt_q] <= '0;
      end else if (commit && cur.we && !mis) begin
        for (int l = 0; l < 4; l++) begin
          if (be[l]) mem_q[widx][8*l +: 8] <= wlane[8*l +: 8];
        end
      end
    end
  end

endmodule
